// File: rtl/draw_pkg.sv
// Screen geometry, colour defaults and FSM encoding shared by the frame renderer
// blocks (frame clear, frame FSM, slice drawer).
package draw_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOR_W  = 3;

  localparam logic [COLOR_W-1:0] CEIL_COLOR  = 3'b001;
  localparam logic [COLOR_W-1:0] FLOOR_COLOR = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // A zero-height wall still shows one pixel; anything taller than the screen fills it.
  function automatic logic [6:0] clamp_size(input logic [6:0] size, input logic [6:0] rows);
    logic [6:0] res;
    if (size == 7'd0) begin
      res = 7'd1;
    end else if (size > rows) begin
      res = rows;
    end else begin
      res = size;
    end
    return res;
  endfunction

endpackage

// File: rtl/slice_bounds.sv
// Vertically centres a wall of the given height: returns first wall row and the
// row just past the wall.
module slice_bounds
  import draw_pkg::*;
#(
  parameter int unsigned ROWS = SCREEN_H
) (
  input  logic [6:0] size,
  output logic [6:0] top,
  output logic [6:0] bot
);

  localparam logic [6:0] ROWS_C = 7'(ROWS);

  logic [6:0] size_c;

  // Clamp, then centre; odd leftovers put the extra row below the wall.
  always_comb begin
    size_c = clamp_size(size, ROWS_C);
    top    = (ROWS_C - size_c) >> 1;
    bot    = top + size_c;
  end

endmodule

// File: rtl/slice_column_drawer.sv
// Streams one screen column (ceiling / wall / floor) into the frame buffer,
// one registered pixel write per cycle, then pulses done.
module slice_column_drawer #(
  parameter int unsigned                          SCREEN_W    = draw_pkg::SCREEN_W,
  parameter int unsigned                          SCREEN_H    = draw_pkg::SCREEN_H,
  parameter logic [draw_pkg::COLOR_W-1:0]         CEIL_COLOR  = draw_pkg::CEIL_COLOR,
  parameter logic [draw_pkg::COLOR_W-1:0]         FLOOR_COLOR = draw_pkg::FLOOR_COLOR
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [7:0]                    column,
  input  logic [6:0]                    slice_size,
  input  logic [draw_pkg::COLOR_W-1:0]  wall_color,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    X,
  output logic [6:0]                    Y,
  output logic [draw_pkg::COLOR_W-1:0]  color_out,
  output logic                          draw_enable
);

  localparam logic [6:0] ROWS     = 7'(SCREEN_H);
  localparam logic [6:0] LAST_ROW = 7'(SCREEN_H - 1);
  localparam logic [8:0] COLS     = 9'(SCREEN_W);

  draw_pkg::state_e state_q, state_d;

  logic [7:0]                   col_q, col_d;
  logic [draw_pkg::COLOR_W-1:0] wall_q, wall_d;
  logic [6:0]                   size_q, size_d;
  logic [6:0]                   top_q, top_d;
  logic [6:0]                   bot_q, bot_d;
  logic [6:0]                   y_q, y_d;
  logic [7:0]                   x_out_q, x_out_d;
  logic [6:0]                   y_out_q, y_out_d;
  logic [draw_pkg::COLOR_W-1:0] color_q, color_d;
  logic                         de_q, de_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic [6:0] bnd_top, bnd_bot;

  slice_bounds #(
    .ROWS (SCREEN_H)
  ) u_bounds (
    .size (size_q),
    .top  (bnd_top),
    .bot  (bnd_bot)
  );

  // State register and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= draw_pkg::ST_IDLE;
      col_q   <= 8'd0;
      wall_q  <= '0;
      size_q  <= 7'd0;
      top_q   <= 7'd0;
      bot_q   <= 7'd0;
      y_q     <= 7'd0;
      x_out_q <= 8'd0;
      y_out_q <= 7'd0;
      color_q <= '0;
      de_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      wall_q  <= wall_d;
      size_q  <= size_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      y_q     <= y_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      color_q <= color_d;
      de_q    <= de_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output decode; pixel fields hold unless a row is being drawn.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    wall_d  = wall_q;
    size_d  = size_q;
    top_d   = top_q;
    bot_d   = bot_q;
    y_d     = y_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    color_d = color_q;
    de_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      draw_pkg::ST_IDLE: begin
        if (start) begin
          col_d   = column;
          wall_d  = wall_color;
          size_d  = draw_pkg::clamp_size(slice_size, ROWS);
          state_d = draw_pkg::ST_CALC;
        end
      end
      draw_pkg::ST_CALC: begin
        top_d = bnd_top;
        bot_d = bnd_bot;
        y_d   = 7'd0;
        if ({1'b0, col_q} >= COLS) begin
          state_d = draw_pkg::ST_DONE;
        end else begin
          state_d = draw_pkg::ST_DRAW;
        end
      end
      draw_pkg::ST_DRAW: begin
        x_out_d = col_q;
        y_out_d = y_q;
        de_d    = 1'b1;
        if (y_q < top_q) begin
          color_d = CEIL_COLOR;
        end else if (y_q < bot_q) begin
          color_d = wall_q;
        end else begin
          color_d = FLOOR_COLOR;
        end
        if (y_q == LAST_ROW) begin
          state_d = draw_pkg::ST_DONE;
        end else begin
          y_d = y_q + 7'd1;
        end
      end
      draw_pkg::ST_DONE: begin
        done_d  = 1'b1;
        state_d = draw_pkg::ST_IDLE;
      end
      default: begin
        state_d = draw_pkg::ST_IDLE;
      end
    endcase
    // busy stays up for the cycle done is visible, then drops in IDLE.
    busy_d = (state_q != draw_pkg::ST_IDLE) || (state_d != draw_pkg::ST_IDLE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign X           = x_out_q;
  assign Y           = y_out_q;
  assign color_out   = color_q;
  assign draw_enable = de_q;

endmodule

// File: tb/tb_slice_column_drawer.sv
// Randomized and directed bench for slice_column_drawer against a per-slice
// model of the expected write list and done timing.
module tb_slice_column_drawer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] column;
  logic [6:0] slice_size;
  logic [2:0] wall_color;
  logic       busy, done, draw_enable;
  logic [7:0] X;
  logic [6:0] Y;
  logic [2:0] color_out;

  int tests = 0;
  int fails = 0;

  slice_column_drawer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .column      (column),
    .slice_size  (slice_size),
    .wall_color  (wall_color),
    .busy        (busy),
    .done        (done),
    .X           (X),
    .Y           (Y),
    .color_out   (color_out),
    .draw_enable (draw_enable)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Colour of screen row y for a slice of requested height sz.
  function automatic logic [2:0] ref_color(input int sz, input logic [2:0] wc, input int y);
    int s, t, b;
    s = (sz == 0) ? 1 : ((sz > 120) ? 120 : sz);
    t = (120 - s) / 2;
    b = t + s;
    if (y < t) return 3'b001;
    if (y < b) return wc;
    return 3'b000;
  endfunction

  function automatic logic [31:0] pack_write(input int n, input logic [7:0] x, input logic [6:0] y,
                                             input logic [2:0] c);
    return (32'(n) << 24) | (32'(x) << 16) | (32'(y) << 8) | 32'(c);
  endfunction

  // Starts one slice at the current negedge and watches it until done is due.
  task automatic run_slice(input logic [7:0] col, input logic [6:0] sz, input logic [2:0] wc,
                           input bit noise);
    logic [31:0] seen[$];
    int          last, n_done, done_at, busy_low, n_exp;
    bit          valid;
    valid    = (col < 8'd160);
    last     = valid ? 122 : 2;
    n_exp    = valid ? 120 : 0;
    n_done   = 0;
    done_at  = -1;
    busy_low = 0;
    column     = col;
    slice_size = sz;
    wall_color = wc;
    start      = 1'b1;
    for (int n = 0; n <= last; n++) begin
      @(negedge clock);
      if (draw_enable) seen.push_back(pack_write(n, X, Y, color_out));
      if (done) begin
        n_done++;
        done_at = n;
      end
      if (!busy) busy_low++;
      start      = 1'b0;
      column     = 8'($urandom_range(0, 255));
      slice_size = 7'($urandom_range(0, 127));
      wall_color = 3'($urandom_range(0, 7));
      if (noise && (n == 50 || n == 121)) start = 1'b1;
    end
    check("busy_window", 32'(busy_low), 32'd0);
    check("done_count", 32'(n_done), 32'd1);
    check("done_cycle", 32'(done_at), 32'(last));
    check("write_count", 32'(seen.size()), 32'(n_exp));
    for (int k = 0; k < n_exp && k < seen.size(); k++) begin
      check("pixel", seen[k], pack_write(2 + k, col, 7'(k), ref_color(int'(sz), wc, k)));
    end
  endtask

  task automatic idle_check();
    @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_de", 32'(draw_enable), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    reset      = 1'b1;
    start      = 1'b0;
    column     = 8'd0;
    slice_size = 7'd0;
    wall_color = 3'd0;
    repeat (2) @(negedge clock);
    check("rst_outputs", {20'd0, busy, done, draw_enable, X, Y, color_out}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Reset in the middle of a slice.
    column = 8'd7; slice_size = 7'd30; wall_color = 3'd6; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (52) @(negedge clock);
    check("pre_rst_row", {24'd0, draw_enable, Y}, {24'd0, 1'b1, 7'd50});
    reset = 1'b1;
    #1;
    check("mid_rst_outputs", {20'd0, busy, done, draw_enable, X, Y, color_out}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clock);
      if (done || draw_enable) dones++;
    end
    check("post_rst_quiet", 32'(dones), 32'd0);
    run_slice(8'd3, 7'd60, 3'd5, 1'b0);
    idle_check();

    // Directed patterns and boundaries.
    run_slice(8'd10, 7'd40, 3'b100, 1'b0);
    idle_check();
    run_slice(8'd11, 7'd41, 3'b010, 1'b0);
    run_slice(8'd12, 7'd0, 3'b111, 1'b0);
    run_slice(8'd13, 7'd127, 3'b011, 1'b0);
    run_slice(8'd159, 7'd80, 3'b110, 1'b0);
    idle_check();
    run_slice(8'd160, 7'd50, 3'b101, 1'b0);
    idle_check();
    run_slice(8'd40, 7'd70, 3'b011, 1'b1);
    run_slice(8'd41, 7'd20, 3'b101, 1'b0);
    idle_check();

    // Randomized slices, some back-to-back, some with ignored start pulses.
    for (int i = 0; i < 20; i++) begin
      run_slice(8'($urandom_range(0, 175)), 7'($urandom_range(0, 127)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
